// File: rtl/abs_adder_rr_arbiter.sv
// Round-robin arbiter sharing one |a| + b adder among N_REQ requesters; IDLE -> CALC -> RESP sequencer.
// Define SAT_ADD_EN to saturate the sum to all-ones whenever the add carries out.
module abs_adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_c_out,
    output logic [ID_W-1:0]          res_id
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_ptr, r_id, r_res_id;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic               r_cout, r_valid;

    logic               w_found, w_hs;
    logic [ID_W-1:0]    w_win, w_idx;
    logic [WIDTH-1:0]   w_a_arr [N_REQ];
    logic [WIDTH-1:0]   w_b_arr [N_REQ];
    logic [WIDTH-1:0]   w_abs, w_sum;
    logic [WIDTH:0]     w_add;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Scan from the highest offset down so the slot nearest r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_hs      = (r_state == IDLE) && w_found;
    assign req_ready = (rst_n && w_hs) ? (N_REQ'(1) << w_win) : '0;

    // Negating the most negative value wraps to itself, which is the right unsigned magnitude.
    assign w_abs = r_a[WIDTH-1] ? (~r_a + WIDTH'(1)) : r_a;
    assign w_add = {1'b0, w_abs} + {1'b0, r_b};

`ifdef SAT_ADD_EN
    assign w_sum = w_add[WIDTH] ? {WIDTH{1'b1}} : w_add[WIDTH-1:0];
`else
    assign w_sum = w_add[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_next = CALC;
            CALC:                   w_next = RESP;
            RESP:    if (res_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_res_id <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_a   <= w_a_arr[w_win];
                r_b   <= w_b_arr[w_win];
                r_id  <= w_win;
                r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
            end
            if (r_state == CALC) begin
                r_sum    <= w_sum;
                r_cout   <= w_add[WIDTH];
                r_res_id <= r_id;
                r_valid  <= 1'b1;
            end
            if (r_state == RESP && res_ready) r_valid <= 1'b0;
        end
    end

    assign res_valid = r_valid;
    assign res_sum   = r_sum;
    assign res_c_out = r_cout;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_abs_adder_rr_arbiter.sv
// Directed + random bench for abs_adder_rr_arbiter against a behavioural arbitration/arithmetic model.
module tb_abs_adder_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_sum;
    logic        res_c_out;
    logic [1:0]  res_id;

    int n_chk = 0;
    int n_pass = 0;
    int ptr = 0;
    int cyc = 0;
    int g_cyc = 0;
    logic [3:0] ta [4];
    logic [3:0] tbv [4];

    abs_adder_rr_arbiter #(.N_REQ(4), .WIDTH(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_c_out(res_c_out), .res_id(res_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {carry, sum} of |a| + b with plain integer arithmetic.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b);
        int av, s;
        av = a[3] ? 16 - int'(a) : int'(a);
        s  = av + int'(b);
`ifdef SAT_ADD_EN
        if (s >= 16) return 5'h1F;
`endif
        return 5'(s);
    endfunction

    function automatic int pick(input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic load();
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = ta[i];
            req_b[i*4 +: 4] = tbv[i];
        end
    endtask

    // Called just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
    task automatic run_op(input string tag, input logic [3:0] m, input int hold, output int win);
        logic [4:0] e;
        load();
        req_valid = m;
        #1;
        win = pick(m);
        check({tag, " grant"}, 32'(req_ready), 32'(1 << win));
        e = model(ta[win], tbv[win]);
        g_cyc = cyc;
        @(negedge clk);
        ptr = (win + 1) % 4;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 4'(~ta[i]);
            tbv[i] = 4'(~tbv[i]);
        end
        load();
        #1;
        check({tag, " calc_rdy"}, 32'(req_ready), 0);
        check({tag, " calc_vld"}, 32'(res_valid), 0);
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            check({tag, " vld"}, 32'(res_valid), 1);
            check({tag, " sum"}, 32'(res_sum), 32'(e[3:0]));
            check({tag, " cout"}, 32'(res_c_out), 32'(e[4]));
            check({tag, " id"}, 32'(res_id), 32'(win));
            check({tag, " resp_rdy"}, 32'(req_ready), 0);
            res_ready = (h == hold);
            @(negedge clk);
        end
        res_ready = 1'b0;
        req_valid = '0;
        #1;
        check({tag, " done_vld"}, 32'(res_valid), 0);
    endtask

    initial begin
        int w;
        int prev;
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst vld", 32'(res_valid), 0);
        check("rst sum", 32'(res_sum), 0);
        check("rst cout", 32'(res_c_out), 0);
        check("rst id", 32'(res_id), 0);
        check("rst rdy", 32'(req_ready), 0);
        rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // Requester 0 alone: |-3| + 2 = 5
        ta[0] = 4'b1101; tbv[0] = 4'd2;
        run_op("t1", 4'b0001, 0, w);
        // Most negative a from requester 3
        ta[3] = 4'b1000; tbv[3] = 4'b1000;
        run_op("t2", 4'b1000, 0, w);

        // Everyone asking with res_ready high: strict rotation, 3 cycles apart
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin ta[j] = 4'($urandom); tbv[j] = 4'($urandom); end
            run_op("t3", 4'hF, 0, w);
            check("t3 order", 32'(w), 32'(i % 4));
            if (prev >= 0) check("t3 spacing", 32'(g_cyc - prev), 3);
            prev = g_cyc;
        end

        // Back-pressure for 5 cycles, then the next grant follows immediately
        ta[1] = 4'd6; tbv[1] = 4'd3;
        run_op("t4", 4'b0010, 5, w);
        prev = cyc;
        ta[2] = 4'b1010; tbv[2] = 4'd1;
        run_op("t4b", 4'b0100, 0, w);
        check("t4 next grant", 32'(g_cyc - prev), 0);

        // Reset pulse while CALC is in flight
        ta[0] = 4'd5; tbv[0] = 4'd5;
        load();
        req_valid = 4'b0001;
        #1;
        w = pick(4'b0001);
        check("t5 grant", 32'(req_ready), 32'(1 << w));
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("t5 rst rdy", 32'(req_ready), 0);
        check("t5 rst vld", 32'(res_valid), 0);
        ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("t5 no result", 32'(res_valid), 0);
        run_op("t5 ptr", 4'hF, 0, w);
        ta[2] = 4'b1110; tbv[2] = 4'd7;
        run_op("t5 req2", 4'b0100, 0, w);

        // Carry boundary and -1
        ta[0] = 4'b0111; tbv[0] = 4'b1001;
        run_op("t6a", 4'b0001, 0, w);
        ta[1] = 4'b1111; tbv[1] = 4'd0;
        run_op("t6b", 4'b0010, 0, w);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                check("idle rdy", 32'(req_ready), 0);
                @(negedge clk);
            end
            for (int j = 0; j < 4; j++) begin ta[j] = 4'($urandom); tbv[j] = 4'($urandom); end
            run_op("rand", 4'($urandom_range(1, 15)), $urandom_range(0, 2), w);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
